display_arbiter: RTL
====================

// Module: display_arbiter
// PURPOSE
//  Shares the four-digit seven-segment display between NUM_REQ requesters.
//  Each requester presents a 16-bit BCD/hex value plus a request line.
//  Grants are round-robin with a minimum dwell time, so every active source
//  is shown for a readable interval. Outputs digit_1..digit_4 drive the
//  display mux/decoder path directly.
// PARAMETERS
//  NUM_REQ       4       number of requesters (2..8)
//  DWELL_CYCLES  100000  min clocks an owner keeps the display when others wait (>=1)
//  CNT_W         17      dwell/blank counter width; must hold DWELL_CYCLES-1
//  BLANK_CYCLES  1000    blank gap length in clocks, DISPLAY_ARB_BLANK_EN only (>=1)
// PORTS
//  clock    in   1          system clock, all logic on rising edge
//  reset_n  in   1          synchronous reset, active-low
//  req      in   NUM_REQ    req[i]=1: requester i wants the display
//  value    in   16*NUM_REQ requester i value at value[16*i+15:16*i]
//  grant    out  NUM_REQ    one-hot current owner; all-zero when none
//  valid    out  1          1 while digits show an owner's value
//  digit_1  out  4          owner value[3:0]   (registered)
//  digit_2  out  4          owner value[7:4]
//  digit_3  out  4          owner value[11:8]
//  digit_4  out  4          owner value[15:12]
// BEHAVIOUR
//  - All outputs registered. While reset_n=0 at an edge: state=IDLE, grant=0,
//    valid=0, digits=0, counter=0, last_owner=NUM_REQ-1 (requester 0 wins first).
//  - Reset mid-operation aborts any grant/blank at that edge; no residue.
//  - RR pick: first i with req[i]=1 searching last_owner+1, +2, ... modulo NUM_REQ.
//  - IDLE: if |req, pick by RR; next edge -> OWN, grant/valid/digits update
//    together (1-clock latency req->grant), counter=0, last_owner=pick.
//  - OWN: digits reload value[owner] every edge (1-clock tracking latency).
//    Counter increments, saturates at DWELL_CYCLES-1.
//    * req[owner]=0: release immediately (dwell ignored). If other req pending
//      -> switch; else -> IDLE (grant=0, valid=0, digits=0).
//    * req[owner]=1, counter==DWELL_CYCLES-1, another req pending -> switch.
//    * Lone requester stays owner indefinitely; counter stays saturated.
//  - Switch (no blank): new owner = RR pick excluding old owner; grant, digits,
//    last_owner change on the same edge; counter=0.
//  - Simultaneous requests: resolved solely by RR order; never two grant bits.
//  - Counter arithmetic unsigned CNT_W bits; never wraps.
// CONFIGURATION
//  DISPLAY_ARB_BLANK_EN defined: every switch passes through BLANK for
//    BLANK_CYCLES clocks: grant=0, valid=0, digits=0. At blank end, re-run RR
//    from last_owner over current req (old owner eligible last); none -> IDLE.
//    Release-to-IDLE and IDLE->OWN take no blank.
//  Undefined: BLANK state absent; switches are single-edge as above.
// TESTING (bench params: NUM_REQ=4, DWELL_CYCLES=8, BLANK_CYCLES=4)
//  1 reset: reset_n=0 during OWN -> next edge grant=0, valid=0, all digits=0.
//  2 req=4'b0100, value[47:32]=16'h1234 -> 1 edge later grant=4'b0100, valid=1,
//    digit_4..digit_1=1,2,3,4; change value to 16'h5678 -> digits follow 1 edge later.
//  3 req=4'b1111 after reset -> grant 0001,0010,0100,1000,0001 each held 8 clocks.
//  4 owner 0001 drops req at clock 3, req=4'b1000 -> next edge grant=1000;
//    repeat with req=0 -> IDLE, valid=0, digits=0.
//  5 lone req=4'b0010 held 50 clocks -> grant=0010 throughout, no glitch.
//  6 BLANK_EN: req=4'b0011 -> grant 0001 8 clocks, 4 clocks grant=0/valid=0,
//    then 0010; drop req[1] during blank -> back to 0001 after blank.

Source files
------------

// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : display_arbiter
// Brief    : Round-robin owner of a shared 4-digit display with minimum dwell.
//            Optional blank gap between owners: define DISPLAY_ARB_BLANK_EN.
// Revision : 1.0
// ============================================================================
module display_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 100000,
  parameter int CNT_W        = 17,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  value,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   valid,
  output logic [3:0]             digit_1,
  output logic [3:0]             digit_2,
  output logic [3:0]             digit_3,
  output logic [3:0]             digit_4
);

  localparam int              C_IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] C_DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [C_IDX_W-1:0] C_LAST_RST = C_IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1
`ifdef DISPLAY_ARB_BLANK_EN
    , ST_BLANK = 2'd2
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic [15:0]          digits_q, digits_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [C_IDX_W-1:0]   owner_q, owner_d;
  logic [C_IDX_W-1:0]   last_q, last_d;

  // Returns {found, index}: first set bit of mask after base, wrapping so base is tried last.
  function automatic logic [C_IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input logic [C_IDX_W-1:0] base);
    logic               found;
    logic [C_IDX_W-1:0] idx;
    int                 k;
    found = 1'b0;
    idx   = '0;
    for (int n = 1; n <= NUM_REQ; n++) begin
      k = (int'(base) + n) % NUM_REQ;
      if (!found && mask[k]) begin
        found = 1'b1;
        idx   = C_IDX_W'(k);
      end
    end
    return {found, idx};
  endfunction

  logic [NUM_REQ-1:0] others;
  logic [C_IDX_W:0]   pick_all;
  logic [C_IDX_W:0]   pick_oth;
  logic               own_req;
  logic               do_switch;

  always_comb begin
    others    = req & ~grant_q;
    own_req   = |(req & grant_q);
    pick_all  = rr_pick(req, last_q);
    pick_oth  = rr_pick(others, owner_q);
    do_switch = (|others) && (!own_req || (cnt_q == C_DWELL_MAX));

    state_d  = state_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_all[C_IDX_W]) begin
          state_d  = ST_OWN;
          owner_d  = pick_all[C_IDX_W-1:0];
          last_d   = pick_all[C_IDX_W-1:0];
          grant_d  = NUM_REQ'(1) << pick_all[C_IDX_W-1:0];
          valid_d  = 1'b1;
          digits_d = value[16*pick_all[C_IDX_W-1:0] +: 16];
          cnt_d    = '0;
        end
      end
      ST_OWN: begin
        digits_d = value[16*owner_q +: 16];
        if (cnt_q != C_DWELL_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (do_switch) begin
`ifdef DISPLAY_ARB_BLANK_EN
          // last_q keeps the old owner so the post-blank search ranks it last.
          state_d  = ST_BLANK;
          grant_d  = '0;
          valid_d  = 1'b0;
          digits_d = '0;
          cnt_d    = '0;
`else
          owner_d  = pick_oth[C_IDX_W-1:0];
          last_d   = pick_oth[C_IDX_W-1:0];
          grant_d  = NUM_REQ'(1) << pick_oth[C_IDX_W-1:0];
          digits_d = value[16*pick_oth[C_IDX_W-1:0] +: 16];
          cnt_d    = '0;
`endif
        end else if (!own_req) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          valid_d  = 1'b0;
          digits_d = '0;
          cnt_d    = '0;
        end
      end
`ifdef DISPLAY_ARB_BLANK_EN
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          cnt_d = '0;
          if (pick_all[C_IDX_W]) begin
            state_d  = ST_OWN;
            owner_d  = pick_all[C_IDX_W-1:0];
            last_d   = pick_all[C_IDX_W-1:0];
            grant_d  = NUM_REQ'(1) << pick_all[C_IDX_W-1:0];
            valid_d  = 1'b1;
            digits_d = value[16*pick_all[C_IDX_W-1:0] +: 16];
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        valid_d  = 1'b0;
        digits_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      digits_q <= '0;
      cnt_q    <= '0;
      owner_q  <= '0;
      last_q   <= C_LAST_RST;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
    end
  end

  assign grant   = grant_q;
  assign valid   = valid_q;
  assign digit_1 = digits_q[3:0];
  assign digit_2 = digits_q[7:4];
  assign digit_3 = digits_q[11:8];
  assign digit_4 = digits_q[15:12];

endmodule
`default_nettype wire
